// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite request arbiter: default bus widths
// and the 2-bit FSM state encodings.
package axi4lite_pkg;

   localparam int C_ADDR_W_DEF = 2;
   localparam int C_DATA_W_DEF = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. When both requests are pending, the one that
// was not granted last wins; a sole request always wins.
module rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_grant,
   output logic       o_grant_valid
);

   // Grant index and valid flag from the pending requests and last-grant pointer
   always_comb begin
      o_grant_valid = |i_req;
      if (&i_req) o_grant = ~i_last;
      else        o_grant = i_req[1];
   end

endmodule

// File: rtl/axi4lite_req_arbiter.sv
// Arbitrates two command requesters onto one AXI4-Lite style master port.
// One transaction is in flight at a time; requesters are served round-robin.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no transaction; accept a requester if any is valid
// ST_ISSUE | pulse mst_start_write or mst_start_read for one cycle
// ST_WAIT  | wait for mst_done, capture read data
// ST_RESP  | pulse the granted requester's resp_valid, update pointer
module axi4lite_req_arbiter
   import axi4lite_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = C_ADDR_W_DEF,
   parameter int C_M_AXI_DATA_WIDTH = C_DATA_W_DEF
) (
   input  logic                          m_axi_aclk,
   input  logic                          m_axi_aresetn,

   input  logic                          req0_valid,
   input  logic                          req0_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] req0_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] req0_wdata,
   output logic                          req0_ready,
   output logic                          req0_resp_valid,
   output logic [C_M_AXI_DATA_WIDTH-1:0] req0_resp_rdata,

   input  logic                          req1_valid,
   input  logic                          req1_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] req1_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] req1_wdata,
   output logic                          req1_ready,
   output logic                          req1_resp_valid,
   output logic [C_M_AXI_DATA_WIDTH-1:0] req1_resp_rdata,

   output logic                          mst_start_write,
   output logic                          mst_start_read,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] mst_write_addr,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] mst_read_addr,
   output logic [C_M_AXI_DATA_WIDTH-1:0] mst_wdata,
   input  logic                          mst_done,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] mst_read_data,

   output logic                          busy,
   output logic                          grant_id
);

   state_t                        r_state;
   logic                          r_last;
   logic                          r_grant_id;
   logic                          r_write;
   logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_rdata0;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_rdata1;

   logic                          w_grant;
   logic                          w_grant_valid;
   logic                          w_accept;
   logic                          w_sel_write;
   logic [C_M_AXI_ADDR_WIDTH-1:0] w_sel_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0] w_sel_wdata;
   logic                          w_done;

   rr_arbiter2 u_rr (
      .i_req         ({req1_valid, req0_valid}),
      .i_last        (r_last),
      .o_grant       (w_grant),
      .o_grant_valid (w_grant_valid)
   );

   // Accept decode and command field mux for the winning requester; gated by
   // reset so ready stays low while the block is held in reset
   always_comb begin
      w_accept    = (r_state == ST_IDLE) & w_grant_valid & m_axi_aresetn;
      w_sel_write = w_grant ? req1_write : req0_write;
      w_sel_addr  = w_grant ? req1_addr  : req0_addr;
      w_sel_wdata = w_grant ? req1_wdata : req0_wdata;
      w_done      = (r_state == ST_WAIT) & mst_done;
   end

   // Transaction FSM plus latched command and grant bookkeeping
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_state    <= ST_IDLE;
         r_last     <= 1'b1;
         r_grant_id <= 1'b0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state    <= ST_ISSUE;
                  r_grant_id <= w_grant;
                  r_write    <= w_sel_write;
                  r_addr     <= w_sel_addr;
                  r_wdata    <= w_sel_wdata;
               end
            end
            ST_ISSUE: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (mst_done) r_state <= ST_RESP;
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_last  <= r_grant_id;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Read data capture into the served requester's holding register only
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else if (w_done) begin
         if (r_grant_id) r_rdata1 <= mst_read_data;
         else            r_rdata0 <= mst_read_data;
      end
   end

   // Output decode from state and latched command
   always_comb begin
      req0_ready      = w_accept & ~w_grant;
      req1_ready      = w_accept &  w_grant;
      req0_resp_valid = (r_state == ST_RESP) & ~r_grant_id;
      req1_resp_valid = (r_state == ST_RESP) &  r_grant_id;
      req0_resp_rdata = r_rdata0;
      req1_resp_rdata = r_rdata1;
      mst_start_write = (r_state == ST_ISSUE) &  r_write;
      mst_start_read  = (r_state == ST_ISSUE) & ~r_write;
      mst_write_addr  = r_addr;
      mst_read_addr   = r_addr;
      mst_wdata       = r_wdata;
      busy            = (r_state != ST_IDLE);
      grant_id        = r_grant_id;
   end

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// Randomized bench for axi4lite_req_arbiter. The bench plays both requesters
// and the master; a transaction-level model predicts grants, start pulses,
// response timing and read data.
module tb_axi4lite_req_arbiter;

   localparam int AW = 2;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid, req0_write, req0_ready, req0_resp_valid;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, req0_resp_rdata;
   logic          req1_valid, req1_write, req1_ready, req1_resp_valid;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, req1_resp_rdata;
   logic          mst_start_write, mst_start_read, mst_done;
   logic [AW-1:0] mst_write_addr, mst_read_addr;
   logic [DW-1:0] mst_wdata, mst_read_data;
   logic          busy, grant_id;

   always #5 clk = ~clk;

   axi4lite_req_arbiter #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_resp_valid(req0_resp_valid),
      .req0_resp_rdata(req0_resp_rdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_resp_valid(req1_resp_valid),
      .req1_resp_rdata(req1_resp_rdata),
      .mst_start_write(mst_start_write), .mst_start_read(mst_start_read),
      .mst_write_addr(mst_write_addr), .mst_read_addr(mst_read_addr), .mst_wdata(mst_wdata),
      .mst_done(mst_done), .mst_read_data(mst_read_data),
      .busy(busy), .grant_id(grant_id)
   );

   int n_checks = 0;
   int n_errors = 0;

   // requester side: pending command per requester
   bit            pend [2];
   bit            pw   [2];
   logic [AW-1:0] pa   [2];
   logic [DW-1:0] pd   [2];

   // next-cycle drive values
   bit            d_valid [2];
   bit            d_write [2];
   logic [AW-1:0] d_addr  [2];
   logic [DW-1:0] d_wdata [2];
   bit            d_done;
   logic [DW-1:0] d_rdata;

   // stimulus knobs
   int p_new     = 0;
   bit contend   = 0;
   bit spurious  = 0;
   int fixed_dly = 0;

   // transaction model
   int            cyc = 0;
   bit            infl;
   int            in_id;
   bit            in_w;
   logic [AW-1:0] in_a;
   logic [DW-1:0] in_d;
   int            acc_cyc, last_acc, start_cyc, done_cyc;
   bit            started, done_given;
   logic [DW-1:0] given;
   logic [DW-1:0] exp_rd [2];
   bit            known  [2];
   int            m_last;
   int            n_resp = 0;
   int            grant_log[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
      end
   endtask

   task automatic model_reset();
      infl = 0; started = 0; done_given = 0;
      m_last = 1; last_acc = -100; acc_cyc = -100; done_cyc = -100;
      for (int n = 0; n < 2; n++) begin exp_rd[n] = '0; known[n] = 1; end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rdy0"}, int'(req0_ready), 0);
      chk({tag, "_rdy1"}, int'(req1_ready), 0);
      chk({tag, "_rv0"}, int'(req0_resp_valid), 0);
      chk({tag, "_rv1"}, int'(req1_resp_valid), 0);
      chk({tag, "_rd0"}, int'(req0_resp_rdata), 0);
      chk({tag, "_rd1"}, int'(req1_resp_rdata), 0);
      chk({tag, "_sw"}, int'(mst_start_write), 0);
      chk({tag, "_sr"}, int'(mst_start_read), 0);
      chk({tag, "_wa"}, int'(mst_write_addr), 0);
      chk({tag, "_ra"}, int'(mst_read_addr), 0);
      chk({tag, "_wd"}, int'(mst_wdata), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_gid"}, int'(grant_id), 0);
   endtask

   task automatic apply();
      req0_valid = d_valid[0]; req0_write = d_write[0]; req0_addr = d_addr[0]; req0_wdata = d_wdata[0];
      req1_valid = d_valid[1]; req1_write = d_write[1]; req1_addr = d_addr[1]; req1_wdata = d_wdata[1];
      mst_done = d_done; mst_read_data = d_rdata;
   endtask

   task automatic drive_reqs();
      for (int n = 0; n < 2; n++) begin
         d_valid[n] = pend[n];
         d_write[n] = pend[n] ? pw[n] : 1'($urandom_range(1, 0));
         d_addr[n]  = pend[n] ? pa[n] : AW'($urandom);
         d_wdata[n] = pend[n] ? pd[n] : DW'($urandom);
      end
   endtask

   task automatic observe();
      bit rd0, rd1, rv0, rv1, sw, sr, infl0, exp_acc, exp_resp, exp_start;
      int win, exp_w;
      rd0 = req0_ready; rd1 = req1_ready;
      rv0 = req0_resp_valid; rv1 = req1_resp_valid;
      sw = mst_start_write; sr = mst_start_read;
      infl0 = infl;

      chk("busy", int'(busy), int'(infl0));
      if (infl && started && !done_given && cyc == done_cyc) done_given = 1;

      exp_resp = infl && done_given && cyc == done_cyc + 1;
      if (rv0 || rv1 || exp_resp) begin
         chk("resp_present", int'(rv0 | rv1), int'(exp_resp));
         chk("resp_id", int'({rv1, rv0}), exp_resp ? (in_id == 1 ? 2 : 1) : 0);
         if (exp_resp) begin
            chk("grant_id", int'(grant_id), in_id);
            chk("addr_hold_w", int'(mst_write_addr), int'(in_a));
            chk("addr_hold_r", int'(mst_read_addr), int'(in_a));
            if (in_w) known[in_id] = 0;
            else begin exp_rd[in_id] = given; known[in_id] = 1; end
            if (known[0]) chk("rdata0", int'(req0_resp_rdata), int'(exp_rd[0]));
            if (known[1]) chk("rdata1", int'(req1_resp_rdata), int'(exp_rd[1]));
            infl = 0;
            n_resp++;
         end
      end

      exp_acc = !infl0 && (pend[0] || pend[1]);
      if (rd0 || rd1 || exp_acc) begin
         chk("accept", int'(rd0 | rd1), int'(exp_acc));
         if (rd0 || rd1) begin
            chk("ready_onehot", int'(rd0 & rd1), 0);
            win = rd1 ? 1 : 0;
            exp_w = (pend[0] && pend[1]) ? 1 - m_last : (pend[1] ? 1 : 0);
            chk("rr_grant", win, exp_w);
            if (last_acc >= 0) chk("accept_spacing", int'(cyc - last_acc >= 4), 1);
            last_acc = cyc; acc_cyc = cyc;
            infl = 1; in_id = win; in_w = pw[win]; in_a = pa[win]; in_d = pd[win];
            pend[win] = 0; m_last = win; started = 0; done_given = 0;
            grant_log.push_back(win);
         end
      end

      exp_start = infl && !started && cyc == acc_cyc + 1;
      if (sw || sr || exp_start) begin
         chk("start_excl", int'(sw & sr), 0);
         chk("start_present", int'(sw | sr), int'(exp_start));
         if (exp_start) begin
            chk("start_kind", int'(sw), int'(in_w));
            chk("start_waddr", int'(mst_write_addr), int'(in_a));
            chk("start_raddr", int'(mst_read_addr), int'(in_a));
            if (in_w) chk("start_wdata", int'(mst_wdata), int'(in_d));
            started = 1; start_cyc = cyc;
            done_cyc = cyc + (fixed_dly > 0 ? fixed_dly : int'($urandom_range(5, 1)));
         end
      end
   endtask

   task automatic plan();
      d_rdata = DW'($urandom);
      if (infl && started && !done_given && cyc + 1 == done_cyc) begin
         d_done = 1; given = d_rdata;
      end else if (spurious && !(infl && started && !done_given))
         d_done = 1'($urandom_range(1, 0));
      else
         d_done = 0;
      for (int n = 0; n < 2; n++) begin
         if (!pend[n] && (contend || int'($urandom_range(99, 0)) < p_new)) begin
            pend[n] = 1; pw[n] = 1'($urandom_range(1, 0));
            pa[n] = AW'($urandom); pd[n] = DW'($urandom);
         end
      end
      drive_reqs();
   endtask

   task automatic tick_body();
      apply();
      @(negedge clk);
      cyc++;
      observe();
      plan();
   endtask

   task automatic tick();
      @(posedge clk); #1;
      tick_body();
   endtask

   task automatic run_txn(input int n, input int budget);
      int target;
      target = n_resp + n;
      while (n_resp < target && budget > 0) begin tick(); budget--; end
      chk("txn_budget", n_resp, target);
   endtask

   task automatic set_req(input int n, input bit w, input int a, input int d);
      pend[n] = 1; pw[n] = w; pa[n] = AW'(a); pd[n] = DW'(d);
      drive_reqs();
   endtask

   initial begin
      int base, guard;
      for (int n = 0; n < 2; n++) pend[n] = 0;
      d_done = 0; d_rdata = '0;
      drive_reqs();
      model_reset();
      apply();
      #12;
      check_zero("reset");
      @(posedge clk); #1; rst_n = 1;
      tick_body();

      // single write, done 3 cycles after start
      fixed_dly = 3;
      set_req(0, 1, 2, 'hA5);
      run_txn(1, 40);
      repeat (2) tick();

      // req0 read so its rdata becomes known, then req1 read
      fixed_dly = 2;
      set_req(0, 0, 3, 0);
      run_txn(1, 40);
      set_req(1, 0, 1, 0);
      run_txn(1, 40);
      repeat (2) tick();

      // minimum-latency done (same cycle WAIT is entered)
      fixed_dly = 1;
      set_req(1, 1, 0, 'h5A);
      run_txn(1, 40);

      // spurious done pulses outside WAIT
      spurious = 1; fixed_dly = 0; p_new = 30;
      run_txn(20, 800);
      spurious = 0; p_new = 0;
      run_txn(0, 10);

      // reset while waiting on the master, then contended traffic
      contend = 1; fixed_dly = 10;
      guard = 100;
      while (!(infl && started) && guard > 0) begin tick(); guard--; end
      chk("reach_wait", int'(infl && started), 1);
      tick(); tick();
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      check_zero("rst_async");
      @(negedge clk);
      check_zero("rst_hold");
      @(posedge clk); #1;
      rst_n = 1;
      model_reset();
      d_done = 0;
      base = grant_log.size();
      tick_body();
      fixed_dly = 1;
      run_txn(4, 80);
      if (grant_log.size() >= base + 4) begin
         for (int k = 0; k < 4; k++) chk("contend_order", grant_log[base + k], k % 2);
      end else chk("contend_count", grant_log.size() - base, 4);

      // long random run
      contend = 0; fixed_dly = 0;
      for (int k = 0; k < 10; k++) begin
         p_new = int'($urandom_range(80, 10));
         spurious = 1'($urandom_range(1, 0));
         run_txn(100, 3000);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
